demux_one_to_two_32bit_buffered: RTL and testbench
==================================================

// Module: demux_one_to_two_32bit_buffered
// PURPOSE
//  Routes one 32-bit valid/ready source to one of two destinations chosen per word by in_sel.
//  Each destination has its own small FIFO, so a stalled consumer does not block the other.
//  Used where one datapath result must be steered to two consumers, for example the register
//  write-back path and a memory/debug sink.
// PARAMETERS
//  WIDTH  32  data width of the input and of both outputs
//  DEPTH  2   entries per output FIFO; power of two, >= 2
//  CNT_W  16  width of the transfer counters; used only when DEMUX_COUNT_EN is defined
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous reset, active-low
//  in_data    in   WIDTH  input word
//  in_sel     in   1      destination: 0 -> out1, 1 -> out2
//  in_valid   in   1      input word present
//  in_ready   out  1      selected FIFO can accept a word
//  out1_data  out  WIDTH  head of FIFO 1
//  out1_valid out  1      FIFO 1 not empty
//  out1_ready in   1      consumer 1 accepts the head word
//  out2_data  out  WIDTH  head of FIFO 2
//  out2_valid out  1      FIFO 2 not empty
//  out2_ready in   1      consumer 2 accepts the head word
//  cnt_clr    in   1      synchronous counter clear (DEMUX_COUNT_EN only)
//  out1_cnt   out  CNT_W  completed out1 handshakes (DEMUX_COUNT_EN only)
//  out2_cnt   out  CNT_W  completed out2 handshakes (DEMUX_COUNT_EN only)
// BEHAVIOUR
//  - Reset (rst_n low, asynchronous):
//    - all pointers and occupancy counts go to 0;
//    - out1_valid = out2_valid = 0 and out1_data = out2_data = 0;
//    - in_ready = 1 once reset is released, because both FIFOs are empty.
//  - in_ready = !full[in_sel]. This is combinational from in_sel; in_valid does not affect it.
//  - Push: on a clk edge with in_valid & in_ready, in_data is written to FIFO[in_sel] at wr_ptr.
//    wr_ptr advances modulo DEPTH and the occupancy count increments.
//  - Pop: on a clk edge with outX_valid & outX_ready, FIFO X rd_ptr advances modulo DEPTH.
//  - outX_valid = (countX != 0).
//  - outX_data = mem[rd_ptr] when valid, 0 when empty. It holds stable while valid & !ready.
//  - Latency: a word pushed at edge N appears on outX in the cycle after edge N.
//    There is no combinational in->out path.
//  - Push and pop on the same FIFO in the same edge: allowed when not full; the count is unchanged.
//  - Full FIFO with a pop in the same cycle: in_ready stays 0 for that FIFO. There is no
//    pass-through; the next push is accepted one cycle later.
//  - Empty FIFO: there is no bypass; a word always spends 1 cycle in storage.
//  - Ordering: words to the same output leave in push order. There is no ordering guarantee
//    across the two outputs.
//  - Independence: a full FIFO 2 with in_sel = 0 keeps in_ready = 1 (no head-of-line
//    blocking on sel change).
//  - in_valid low: no state change, whatever in_data or in_sel do.
//  - Reset mid-operation: FIFO contents are discarded. No word pushed before reset appears after it.
// CONFIGURATION
//  - DEMUX_COUNT_EN defined:
//    - adds cnt_clr, out1_cnt and out2_cnt;
//    - outX_cnt increments on each outX handshake and wraps at 2^CNT_W;
//    - cnt_clr has priority over an increment in the same cycle;
//    - rst_n resets both counters to 0.
//  - DEMUX_COUNT_EN undefined: those ports and the counter logic are absent;
//    all other behaviour is identical.
// TESTING
//  1. After reset, push 0xDEADBEEF with sel=0 and out1_ready=1 -> next cycle out1_valid=1,
//     out1_data=0xDEADBEEF; out2_valid stays 0.
//  2. With out2_ready=0, push 0x1 then 0x2 with sel=1 -> in_ready=0 while sel=1 and =1 while sel=0.
//     Then raise out2_ready -> 0x1 is delivered, then 0x2.
//  3. Stream 0x10..0x1F, alternating sel, both readys high -> one word per cycle with no bubbles;
//     evens on out1 and odds on out2, in order.
//  4. Both FIFOs hold 2 words; pull rst_n low between edges -> valids and data are 0 immediately.
//     After release, nothing is emitted.
//  5. DEMUX_COUNT_EN, CNT_W=2: 5 out1 transfers and 1 out2 transfer -> out1_cnt=1 (wrapped),
//     out2_cnt=1. cnt_clr during an out1 transfer -> out1_cnt=0.
//  6. in_valid=0 while in_data and in_sel toggle for 10 cycles -> both valids stay 0 and in_ready stays 1.

Source files
------------

// File: rtl/demux_one_to_two_32bit_buffered.sv
// 1:2 valid/ready demultiplexer with an independent FIFO per destination.
// Optional handshake counters: define DEMUX_COUNT_EN to add cnt_clr, out1_cnt and out2_cnt.
module demux_one_to_two_32bit_buffered #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out1_data,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [WIDTH-1:0] out2_data,
   output logic             out2_valid,
   input  logic             out2_ready
`ifdef DEMUX_COUNT_EN
   ,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] out1_cnt,
   output logic [CNT_W-1:0] out2_cnt
`endif
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned OCC_W = $clog2(DEPTH + 1);

   // Reject configurations the pointer arithmetic cannot handle.
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("DEPTH must be a power of two >= 2");
   end
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("CNT_W must be >= 1");
   end

   logic [1:0]       push;
   logic [1:0]       pop;
   logic [1:0]       full;
   logic [1:0]       valid;
   logic [1:0]       ready;
   logic [WIDTH-1:0] head [2];

   assign ready = {out2_ready, out1_ready};

   // Only the selected FIFO's fullness gates the input; in_valid never feeds back into in_ready.
   assign in_ready = in_sel ? ~full[1] : ~full[0];
   assign push[0]  = in_valid & ~in_sel & ~full[0];
   assign push[1]  = in_valid &  in_sel & ~full[1];
   assign pop      = valid & ready;

   for (genvar i = 0; i < 2; i++) begin : g_fifo
      logic [WIDTH-1:0] mem [DEPTH];
      logic [PTR_W-1:0] wr_ptr;
      logic [PTR_W-1:0] rd_ptr;
      logic [OCC_W-1:0] count;

      // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push[i]) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop[i])  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push[i], pop[i]})
               2'b10:   count <= count + OCC_W'(1);
               2'b01:   count <= count - OCC_W'(1);
               default: count <= count;
            endcase
         end
      end

      // Storage needs no reset: an entry is only visible while count covers it.
      always_ff @(posedge clk) begin
         if (push[i]) mem[wr_ptr] <= in_data;
      end

      assign full[i]  = (count == OCC_W'(DEPTH));
      assign valid[i] = (count != '0);
      assign head[i]  = valid[i] ? mem[rd_ptr] : '0;
   end

   assign out1_valid = valid[0];
   assign out2_valid = valid[1];
   assign out1_data  = head[0];
   assign out2_data  = head[1];

`ifdef DEMUX_COUNT_EN
   // Completed-handshake counters; clear wins over a same-cycle increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out1_cnt <= '0;
         out2_cnt <= '0;
      end else if (cnt_clr) begin
         out1_cnt <= '0;
         out2_cnt <= '0;
      end else begin
         if (pop[0]) out1_cnt <= out1_cnt + CNT_W'(1);
         if (pop[1]) out2_cnt <= out2_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_demux_one_to_two_32bit_buffered.sv
// Directed self-checking bench for demux_one_to_two_32bit_buffered (counters when DEMUX_COUNT_EN).
module tb_demux_one_to_two_32bit_buffered;

`ifdef DEMUX_COUNT_EN
   localparam int unsigned CW = 2;
`else
   localparam int unsigned CW = 16;
`endif

   logic        clk;
   logic        rst_n;
   logic [31:0] in_data;
   logic        in_sel;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out1_data;
   logic        out1_valid;
   logic        out1_ready;
   logic [31:0] out2_data;
   logic        out2_valid;
   logic        out2_ready;
`ifdef DEMUX_COUNT_EN
   logic          cnt_clr;
   logic [CW-1:0] out1_cnt;
   logic [CW-1:0] out2_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   demux_one_to_two_32bit_buffered #(
      .WIDTH(32),
      .DEPTH(2),
      .CNT_W(CW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data    (in_data),
      .in_sel     (in_sel),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out1_data  (out1_data),
      .out1_valid (out1_valid),
      .out1_ready (out1_ready),
      .out2_data  (out2_data),
      .out2_valid (out2_valid),
      .out2_ready (out2_ready)
`ifdef DEMUX_COUNT_EN
      ,
      .cnt_clr    (cnt_clr),
      .out1_cnt   (out1_cnt),
      .out2_cnt   (out2_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs set afterwards apply at the following edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n      = 1'b0;
      in_data    = '0;
      in_sel     = 1'b0;
      in_valid   = 1'b0;
      out1_ready = 1'b0;
      out2_ready = 1'b0;
`ifdef DEMUX_COUNT_EN
      cnt_clr    = 1'b0;
`endif

      // Reset state
      #12;
      chk("rst_out1_valid", 32'(out1_valid), 32'd0);
      chk("rst_out2_valid", 32'(out2_valid), 32'd0);
      chk("rst_out1_data", out1_data, 32'd0);
      chk("rst_out2_data", out2_data, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // 1: single word to out1, one-cycle latency
      in_data = 32'hDEADBEEF; in_sel = 1'b0; in_valid = 1'b1; out1_ready = 1'b1;
      chk("t1_in_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      chk("t1_out1_valid", 32'(out1_valid), 32'd1);
      chk("t1_out1_data", out1_data, 32'hDEADBEEF);
      chk("t1_out2_valid", 32'(out2_valid), 32'd0);
      tick();
      chk("t1_out1_drained", 32'(out1_valid), 32'd0);
      chk("t1_out1_data_zero", out1_data, 32'd0);

      // 2: fill FIFO 2 while stalled; in_ready follows in_sel
      out2_ready = 1'b0;
      in_sel = 1'b1; in_data = 32'h1; in_valid = 1'b1;
      tick();
      in_data = 32'h2;
      chk("t2_in_ready_one", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      chk("t2_in_ready_sel1", 32'(in_ready), 32'd0);
      in_sel = 1'b0;
      #1;
      chk("t2_in_ready_sel0", 32'(in_ready), 32'd1);
      chk("t2_head_hold", out2_data, 32'h1);
      tick();
      chk("t2_head_stable", out2_data, 32'h1);
      out2_ready = 1'b1;
      tick();
      chk("t2_second_valid", 32'(out2_valid), 32'd1);
      chk("t2_second_data", out2_data, 32'h2);
      tick();
      chk("t2_drained", 32'(out2_valid), 32'd0);

      // 3: alternating stream, no bubbles, evens -> out1, odds -> out2
      out1_ready = 1'b1; out2_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         in_data  = 32'h10 + 32'(k);
         in_sel   = k[0];
         in_valid = 1'b1;
         #1;
         chk("t3_in_ready", 32'(in_ready), 32'd1);
         tick();
         if (k[0]) begin
            chk("t3_out2_data", out2_data, 32'h10 + 32'(k));
            chk("t3_out1_idle", 32'(out1_valid), 32'd0);
         end else begin
            chk("t3_out1_data", out1_data, 32'h10 + 32'(k));
            chk("t3_out2_idle", 32'(out2_valid), 32'd0);
         end
      end
      in_valid = 1'b0;
      tick();
      chk("t3_out1_empty", 32'(out1_valid), 32'd0);
      chk("t3_out2_empty", 32'(out2_valid), 32'd0);

      // Full FIFO with a pop in the same cycle: no pass-through
      out1_ready = 1'b0;
      in_sel = 1'b0; in_valid = 1'b1; in_data = 32'hC0;
      tick();
      in_data = 32'hC1;
      tick();
      in_data = 32'hC2; out1_ready = 1'b1;
      #1;
      chk("full_pop_in_ready", 32'(in_ready), 32'd0);
      tick();
      chk("full_pop_ready_after", 32'(in_ready), 32'd1);
      chk("full_pop_head", out1_data, 32'hC1);
      out1_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      chk("full_pop_head_hold", out1_data, 32'hC1);
      out1_ready = 1'b1;
      tick();
      chk("full_pop_late_word", out1_data, 32'hC2);
      tick();
      chk("full_pop_drained", 32'(out1_valid), 32'd0);

      // Same-edge push and pop on a one-entry FIFO
      in_sel = 1'b0; in_valid = 1'b1; in_data = 32'hD0;
      tick();
      in_data = 32'hD1;
      tick();
      in_valid = 1'b0;
      chk("pp_valid", 32'(out1_valid), 32'd1);
      chk("pp_data", out1_data, 32'hD1);
      tick();
      chk("pp_drained", 32'(out1_valid), 32'd0);

      // 4: async reset with both FIFOs full
      out1_ready = 1'b0; out2_ready = 1'b0; in_valid = 1'b1;
      in_sel = 1'b0; in_data = 32'hA0; tick();
      in_data = 32'hA1; tick();
      in_sel = 1'b1; in_data = 32'hB0; tick();
      in_data = 32'hB1; tick();
      in_valid = 1'b0;
      chk("t4_pre_out1_valid", 32'(out1_valid), 32'd1);
      chk("t4_pre_out2_data", out2_data, 32'hB0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t4_rst_out1_valid", 32'(out1_valid), 32'd0);
      chk("t4_rst_out2_valid", 32'(out2_valid), 32'd0);
      chk("t4_rst_out1_data", out1_data, 32'd0);
      chk("t4_rst_out2_data", out2_data, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      out1_ready = 1'b1; out2_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("t4_post_out1_valid", 32'(out1_valid), 32'd0);
         chk("t4_post_out2_valid", 32'(out2_valid), 32'd0);
      end
      chk("t4_post_in_ready", 32'(in_ready), 32'd1);

      // 6: in_valid low while data/sel toggle
      out1_ready = 1'b0; out2_ready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         in_valid = 1'b0;
         in_data  = 32'h5A5A0000 ^ 32'(k * 32'h1111);
         in_sel   = k[0];
         tick();
         chk("t6_out1_valid", 32'(out1_valid), 32'd0);
         chk("t6_out2_valid", 32'(out2_valid), 32'd0);
         chk("t6_in_ready", 32'(in_ready), 32'd1);
      end

`ifdef DEMUX_COUNT_EN
      // 5: counter wrap and clear priority (CNT_W = 2)
      out1_ready = 1'b1; out2_ready = 1'b1;
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      chk("t5_clr_out1", 32'(out1_cnt), 32'd0);
      chk("t5_clr_out2", 32'(out2_cnt), 32'd0);
      in_valid = 1'b1; in_sel = 1'b0;
      for (int k = 0; k < 5; k++) begin
         in_data = 32'hE0 + 32'(k);
         tick();
      end
      in_sel = 1'b1; in_data = 32'hF0;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      chk("t5_out1_cnt_wrap", 32'(out1_cnt), 32'd1);
      chk("t5_out2_cnt", 32'(out2_cnt), 32'd1);
      in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hE8;
      tick();
      in_valid = 1'b0; cnt_clr = 1'b1;
      chk("t5_xfer_pending", 32'(out1_valid), 32'd1);
      tick();
      cnt_clr = 1'b0;
      chk("t5_clr_priority", 32'(out1_cnt), 32'd0);
      chk("t5_clr_out2_zero", 32'(out2_cnt), 32'd0);
      chk("t5_word_taken", 32'(out1_valid), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
